aes_stream_ctrl: RTL and testbench
==================================

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 SHALL have parameter BLK_W, default 128, meaning data/block/IV width in bits.
REQ-002 SHALL have parameter NUM_CTX, default 4, meaning number of persistent IV/counter contexts (power of 2, >=2).
REQ-003 SHALL have parameter CTR_W, default 32, meaning CTR-mode counter width, 1..BLK_W, occupying IV bits [CTR_W-1:0].
REQ-004 SHALL have ports `clk` (in, 1, the single clock) and `reset` (in, 1, asynchronous, active-low).
REQ-005 SHALL have port s_tdata/s_tvalid/s_tready/s_tlast (in/in/out/in, BLK_W/1/1/1): the input stream, carrying a command beat followed by key, IV and data beats.
REQ-006 SHALL have port m_tdata/m_tvalid/m_tready/m_tlast (out/out/in/out, BLK_W/1/1/1): the output stream.
REQ-007 SHALL have port core_start (out, 1): a one-cycle start pulse to the external AES core.
REQ-008 SHALL have port core_op (out, 2): 01 = key expansion, 10 = cipher, 11 = decipher.
REQ-009 SHALL have ports core_key256 (out, 1), core_key (out, 2*BLK_W), core_in (out, BLK_W), core_out (in, BLK_W) and core_done (in, 1, one-cycle pulse).
REQ-010 SHALL have port err_cmd (out, 1): a one-cycle pulse on an illegal command.

Function
REQ-011 SHALL decode the command beat as: [1:0] mode (00 ECB, 01 CBC, 10 CTR, 11 illegal); [2] decrypt; [3] key256; [4] load_key; [5] load_iv; [6+:log2(NUM_CTX)] ctx.
REQ-012 SHALL implement states CMD, KEY_LO, KEY_HI, KEYEXP, IV, BLK_IN, BLK_WAIT, BLK_OUT, DRAIN.
REQ-013 SHALL transition from CMD on a handshake with a legal mode to KEY_LO if load_key is set, else to IV if load_iv is set, else to BLK_IN.
REQ-014 SHALL, in KEY_LO, capture core_key[BLK_W-1:0], then go to KEY_HI if key256 is set, else to KEYEXP.
REQ-015 SHALL, in KEY_HI, capture core_key[2*BLK_W-1:BLK_W], then go to KEYEXP.
REQ-016 SHALL, in KEYEXP, issue core_start with core_op=01 on entry, hold s_tready=0 until core_done, then go to IV if load_iv is set, else to BLK_IN.
REQ-017 SHALL, in IV, write the beat into ctx_iv[ctx], then go to BLK_IN.
REQ-018 SHALL, in BLK_IN, latch the block on handshake, pulse core_start the next cycle with the core_op selected by mode/decrypt (CTR always 10), then go to BLK_WAIT.
REQ-019 SHALL drive core_in = blk^iv for CBC-enc, blk for CBC-dec and ECB, and iv for CTR.
REQ-020 SHALL, on core_done, register m_tdata = core_out for ECB and CBC-enc, core_out^iv for CBC-dec, and core_out^blk for CTR, then go to BLK_OUT.
REQ-021 SHALL, on core_done, update ctx_iv[ctx] to core_out for CBC-enc, blk for CBC-dec, unchanged for ECB, and for CTR increment [CTR_W-1:0] modulo 2^CTR_W with the upper bits unchanged.
REQ-022 SHALL hold m_tvalid in BLK_OUT until m_tready, with m_tlast equal to the s_tlast of the latched block.
REQ-023 SHALL, after the output handshake, return to CMD if m_tlast was set, else to BLK_IN.
REQ-024 SHALL hold m_tdata/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-025 SHALL, on an illegal mode, pulse err_cmd and go to DRAIN, or stay in CMD if the command beat has s_tlast.
REQ-026 SHALL, in DRAIN, accept and discard beats (s_tready=1) until a tlast handshake, then go to CMD.
REQ-027 SHALL, on s_tlast in KEY_LO, KEY_HI or IV, abort to CMD without starting the core or modifying ctx_iv, discarding partial key bits.
REQ-028 SHALL, for a command beat with s_tlast and a legal mode, perform the load steps, return to CMD, and produce no output.
REQ-029 SHALL keep ctx_iv contents across packets so that a packet without load_iv continues the context's chain/counter.
REQ-030 SHALL assert s_tready only in CMD, KEY_LO, KEY_HI, IV, BLK_IN and DRAIN, and never while m_tvalid=1.
REQ-031 SHALL ignore core_done in any state other than KEYEXP and BLK_WAIT.

Reset
REQ-032 SHALL, on reset low, asynchronously force: state=CMD, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, core_start=0, core_op=00, err_cmd=0, core_key=0, all ctx_iv=0.
REQ-033 SHALL drive s_tready=1 on the first clock edge after reset rises.
REQ-034 SHALL, on reset assertion mid-operation, discard any in-flight block and produce no output for it.

Verification
REQ-035 SHALL verify CBC chaining: ECB core model, ctx=2, IV=0x00..01, two blocks over two packets (second without load_iv) -> second packet output equals one continuous two-block CBC encryption.
REQ-036 SHALL verify CTR wrap: CTR_W=32, IV=0xAA..AA_FFFFFFFF, two blocks -> second core_in = 0xAA..AA_00000000.
REQ-037 SHALL verify an illegal command: mode=11 with three trailing beats, tlast on the last -> one err_cmd pulse, no m_tvalid, next packet processed normally.
REQ-038 SHALL verify 256-bit key loading: key256=1, load_key=1 -> core_key = {beat2, beat1}, core_start with op 01 once, no core_start before core_done.
REQ-039 SHALL verify backpressure: m_tready=0 for 10 cycles in BLK_OUT -> m_tdata stable, s_tready=0, no data loss.
REQ-040 SHALL verify reset in BLK_WAIT: then a core_done pulse -> no m_tvalid, all ctx_iv=0, state CMD.

Source files
------------

// File: rtl/aes_stream_ctrl_if.sv
// Stream bundle for the AES stream controller: one input stream (command,
// key, IV and data beats) and one output stream (processed blocks).
interface aes_stream_ctrl_if #(
  parameter int BLK_W = 128
);
  logic [BLK_W-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;
  logic [BLK_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  // Controller side: consumes s_*, produces m_*.
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  // Source/sink side: produces s_*, consumes m_*.
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// AES stream controller: decodes a command beat, loads key/IV, sequences an
// external AES core through ECB/CBC/CTR block processing and keeps per-context
// IV/counter state across packets.
module aes_stream_ctrl #(
  parameter int BLK_W   = 128,
  parameter int NUM_CTX = 4,
  parameter int CTR_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_stream_ctrl_if.slave     axis,
  output logic                 core_start,
  output logic [1:0]           core_op,
  output logic                 core_key256,
  output logic [2*BLK_W-1:0]   core_key,
  output logic [BLK_W-1:0]     core_in,
  input  logic [BLK_W-1:0]     core_out,
  input  logic                 core_done,
  output logic                 err_cmd
);

  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam logic [1:0] OP_KEYEXP = 2'b01;
  localparam logic [1:0] OP_ENC    = 2'b10;
  localparam logic [1:0] OP_DEC    = 2'b11;

  typedef enum logic [3:0] {
    CMD      = 4'd0,
    KEY_LO   = 4'd1,
    KEY_HI   = 4'd2,
    KEYEXP   = 4'd3,
    IV       = 4'd4,
    BLK_IN   = 4'd5,
    BLK_WAIT = 4'd6,
    BLK_OUT  = 4'd7,
    DRAIN    = 4'd8
  } state_t;

  state_t             state;
  logic [1:0]         mode_r;
  logic               dec_r;
  logic               k256_r;
  logic               liv_r;
  logic               cmd_last_r;
  logic [CTX_W-1:0]   ctx_r;
  logic [BLK_W-1:0]   key_lo_r;
  logic [BLK_W-1:0]   blk_r;
  logic               blk_last_r;
  logic [BLK_W-1:0]   ctx_iv [NUM_CTX];

  logic               s_hs;
  logic               abort;
  logic [1:0]         cmd_mode;
  logic [CTX_W-1:0]   cmd_ctx;
  logic [BLK_W-1:0]   cur_iv;

  // Counter increment confined to the low CTR_W bits; upper IV bits are a nonce.
  function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] v);
    logic [BLK_W-1:0] r;
    r = v;
    r[CTR_W-1:0] = v[CTR_W-1:0] + CTR_W'(1'b1);
    return r;
  endfunction

  assign s_hs     = axis.s_tvalid & axis.s_tready;
  // A load beat carrying tlast ends a data packet early; a control-only
  // packet (tlast already on the command) legitimately ends after its loads.
  assign abort    = axis.s_tlast & ~cmd_last_r;
  assign cmd_mode = axis.s_tdata[1:0];
  assign cmd_ctx  = axis.s_tdata[6 +: CTX_W];
  assign cur_iv   = ctx_iv[ctx_r];

  // Packet sequencer: state, stream handshakes, core control and context update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= CMD;
      axis.s_tready <= 1'b0;
      axis.m_tvalid <= 1'b0;
      axis.m_tlast  <= 1'b0;
      axis.m_tdata  <= '0;
      core_start    <= 1'b0;
      core_op       <= 2'b00;
      core_key256   <= 1'b0;
      core_key      <= '0;
      core_in       <= '0;
      err_cmd       <= 1'b0;
      mode_r        <= 2'b00;
      dec_r         <= 1'b0;
      k256_r        <= 1'b0;
      liv_r         <= 1'b0;
      cmd_last_r    <= 1'b0;
      ctx_r         <= '0;
      key_lo_r      <= '0;
      blk_r         <= '0;
      blk_last_r    <= 1'b0;
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_iv[i] <= '0;
      end
    end else begin
      core_start <= 1'b0;
      err_cmd    <= 1'b0;
      case (state)
        CMD: begin
          axis.s_tready <= 1'b1;
          if (s_hs) begin
            if (cmd_mode == MODE_BAD) begin
              err_cmd <= 1'b1;
              state   <= axis.s_tlast ? CMD : DRAIN;
            end else begin
              mode_r     <= cmd_mode;
              dec_r      <= axis.s_tdata[2];
              k256_r     <= axis.s_tdata[3];
              liv_r      <= axis.s_tdata[5];
              ctx_r      <= cmd_ctx;
              cmd_last_r <= axis.s_tlast;
              if (axis.s_tdata[4])      state <= KEY_LO;
              else if (axis.s_tdata[5]) state <= IV;
              else if (axis.s_tlast)    state <= CMD;
              else                      state <= BLK_IN;
            end
          end
        end
        KEY_LO: begin
          if (s_hs) begin
            if (abort) begin
              state <= CMD;
            end else if (k256_r) begin
              key_lo_r <= axis.s_tdata;
              state    <= KEY_HI;
            end else begin
              core_key      <= {{BLK_W{1'b0}}, axis.s_tdata};
              core_key256   <= 1'b0;
              core_start    <= 1'b1;
              core_op       <= OP_KEYEXP;
              axis.s_tready <= 1'b0;
              state         <= KEYEXP;
            end
          end
        end
        KEY_HI: begin
          if (s_hs) begin
            if (abort) begin
              state <= CMD;
            end else begin
              core_key      <= {axis.s_tdata, key_lo_r};
              core_key256   <= 1'b1;
              core_start    <= 1'b1;
              core_op       <= OP_KEYEXP;
              axis.s_tready <= 1'b0;
              state         <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          if (core_done) begin
            axis.s_tready <= 1'b1;
            if (liv_r)           state <= IV;
            else if (cmd_last_r) state <= CMD;
            else                 state <= BLK_IN;
          end
        end
        IV: begin
          if (s_hs) begin
            if (abort) begin
              state <= CMD;
            end else begin
              ctx_iv[ctx_r] <= axis.s_tdata;
              state         <= cmd_last_r ? CMD : BLK_IN;
            end
          end
        end
        BLK_IN: begin
          if (s_hs) begin
            blk_r         <= axis.s_tdata;
            blk_last_r    <= axis.s_tlast;
            core_start    <= 1'b1;
            axis.s_tready <= 1'b0;
            state         <= BLK_WAIT;
            case (mode_r)
              MODE_CBC: begin
                core_in <= dec_r ? axis.s_tdata : (axis.s_tdata ^ cur_iv);
                core_op <= dec_r ? OP_DEC : OP_ENC;
              end
              MODE_CTR: begin
                core_in <= cur_iv;
                core_op <= OP_ENC;
              end
              default: begin
                core_in <= axis.s_tdata;
                core_op <= dec_r ? OP_DEC : OP_ENC;
              end
            endcase
          end
        end
        BLK_WAIT: begin
          if (core_done) begin
            axis.m_tvalid <= 1'b1;
            axis.m_tlast  <= blk_last_r;
            state         <= BLK_OUT;
            case (mode_r)
              MODE_CBC: begin
                axis.m_tdata  <= dec_r ? (core_out ^ cur_iv) : core_out;
                ctx_iv[ctx_r] <= dec_r ? blk_r : core_out;
              end
              MODE_CTR: begin
                axis.m_tdata  <= core_out ^ blk_r;
                ctx_iv[ctx_r] <= ctr_inc(cur_iv);
              end
              default: begin
                axis.m_tdata  <= core_out;
              end
            endcase
          end
        end
        BLK_OUT: begin
          if (axis.m_tready) begin
            axis.m_tvalid <= 1'b0;
            axis.s_tready <= 1'b1;
            state         <= axis.m_tlast ? CMD : BLK_IN;
          end
        end
        DRAIN: begin
          axis.s_tready <= 1'b1;
          if (s_hs && axis.s_tlast) begin
            state <= CMD;
          end
        end
        default: begin
          axis.m_tvalid <= 1'b0;
          axis.s_tready <= 1'b1;
          state         <= CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a toy invertible block-cipher core:
// enc(x) = rotl1(x) ^ key_lo, dec(y) = rotr1(y ^ key_lo), three-cycle latency.
module tb_aes_stream_ctrl;
  localparam int BLK_W = 128;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_stream_ctrl_if #(.BLK_W(BLK_W)) axis ();

  logic             core_start;
  logic [1:0]       core_op;
  logic             core_key256;
  logic [255:0]     core_key;
  logic [127:0]     core_in;
  logic [127:0]     core_out = 128'h0;
  logic             core_done;
  logic             err_cmd;
  logic             model_done  = 1'b0;
  logic             manual_done = 1'b0;
  assign core_done = model_done | manual_done;

  aes_stream_ctrl #(.BLK_W(BLK_W), .NUM_CTX(4), .CTR_W(32)) dut (
    .clk(clk), .reset(reset), .axis(axis),
    .core_start(core_start), .core_op(core_op), .core_key256(core_key256),
    .core_key(core_key), .core_in(core_in), .core_out(core_out),
    .core_done(core_done), .err_cmd(err_cmd)
  );

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [127:0] enc(input logic [127:0] x, input logic [127:0] k);
    return {x[126:0], x[127]} ^ k;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] y;
    y = x ^ k;
    return {y[0], y[127:1]};
  endfunction

  // Core model and event monitors, sampled on the falling edge.
  logic         auto_en = 1'b1;
  logic         busy    = 1'b0;
  int           lat     = 0;
  logic [1:0]   m_op    = 2'b00;
  logic [127:0] m_in    = 128'h0;
  int starts = 0, kexp_starts = 0, overlaps = 0, errs_seen = 0, mvalid_seen = 0, ncin = 0;
  logic [127:0] cin_log [8];

  // Toy AES core plus counters for starts, err pulses and output valids.
  always @(negedge clk) begin
    if (!reset) begin
      busy       = 1'b0;
      model_done = 1'b0;
      lat        = 0;
    end else begin
      model_done = 1'b0;
      if (core_start) begin
        starts++;
        if (busy) overlaps++;
        if (core_op == 2'b01) kexp_starts++;
        else begin
          cin_log[ncin % 8] = core_in;
          ncin++;
        end
        if (auto_en) begin
          busy = 1'b1;
          lat  = 3;
          m_op = core_op;
          m_in = core_in;
        end
      end else if (busy) begin
        lat--;
        if (lat == 0) begin
          busy       = 1'b0;
          model_done = 1'b1;
          core_out   = (m_op == 2'b11) ? dec(m_in, core_key[127:0]) : enc(m_in, core_key[127:0]);
        end
      end
    end
    if (err_cmd) errs_seen++;
    if (axis.m_tvalid) mvalid_seen++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int n = 0;
    axis.s_tdata  = d;
    axis.s_tlast  = l;
    axis.s_tvalid = 1'b1;
    while (axis.s_tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_ready_timeout", {255'h0, axis.s_tready}, 256'd1);
    @(posedge clk);
    #1;
    axis.s_tvalid = 1'b0;
    axis.s_tlast  = 1'b0;
    @(negedge clk);
  endtask

  task automatic recv(input logic [127:0] exp_d, input logic exp_l, input int hold, input string tag);
    int n = 0;
    while (axis.m_tvalid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {255'h0, axis.m_tvalid}, 256'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_bp_data"},  {128'h0, axis.m_tdata}, {128'h0, exp_d});
      check({tag, "_bp_ready"}, {255'h0, axis.s_tready}, 256'd0);
    end
    check({tag, "_data"}, {128'h0, axis.m_tdata}, {128'h0, exp_d});
    check({tag, "_last"}, {255'h0, axis.m_tlast}, {255'h0, exp_l});
    axis.m_tready = 1'b1;
    @(posedge clk);
    #1;
    axis.m_tready = 1'b0;
    @(negedge clk);
  endtask

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  localparam logic [127:0] K_LO = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_HI = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] P2   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P3   = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] P5   = 128'h80000000000000000000000000000001;
  localparam logic [127:0] IV1  = 128'h00000000000000000000000000000001;
  localparam logic [127:0] IVC  = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_ffffffff;
  localparam logic [127:0] IVC1 = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_00000000;
  localparam logic [127:0] IVC2 = 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_00000001;
  localparam logic [127:0] D0   = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] D1   = 128'h123456789abcdef00fedcba987654321;

  // Directed sequence.
  initial begin
    logic [127:0] c1, c2;
    int b_st, b_kx, b_ov, b_err, b_mv, b_cin;

    axis.s_tdata  = 128'h0;
    axis.s_tvalid = 1'b0;
    axis.s_tlast  = 1'b0;
    axis.m_tready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_s_tready",  {255'h0, axis.s_tready}, 256'd0);
    check("rst_m_tvalid",  {255'h0, axis.m_tvalid}, 256'd0);
    check("rst_m_tlast",   {255'h0, axis.m_tlast},  256'd0);
    check("rst_m_tdata",   {128'h0, axis.m_tdata},  256'd0);
    check("rst_core_start",{255'h0, core_start},    256'd0);
    check("rst_core_op",   {254'h0, core_op},       256'd0);
    check("rst_err_cmd",   {255'h0, err_cmd},       256'd0);
    check("rst_core_key",  core_key,                256'd0);
    reset = 1'b1;
    check("rel_ready_pre_edge", {255'h0, axis.s_tready}, 256'd0);
    @(negedge clk);
    check("rel_ready_post_edge", {255'h0, axis.s_tready}, 256'd1);

    // 256-bit key load, then one ECB block.
    b_st = starts; b_kx = kexp_starts; b_ov = overlaps;
    send(128'h18, 1'b0);
    send(K_LO, 1'b0);
    send(K_HI, 1'b0);
    check("key_start",   {255'h0, core_start},  256'd1);
    check("key_op",      {254'h0, core_op},     256'd1);
    check("key_value",   core_key,              {K_HI, K_LO});
    check("key_256",     {255'h0, core_key256}, 256'd1);
    check("key_ready0",  {255'h0, axis.s_tready}, 256'd0);
    send(P0, 1'b1);
    recv(enc(P0, K_LO), 1'b1, 0, "ecb");
    check("kexp_once",   256'(kexp_starts - b_kx), 256'd1);
    check("start_count", 256'(starts - b_st),      256'd2);
    check("no_overlap",  256'(overlaps - b_ov),    256'd0);

    // CBC chaining on ctx 2 across two packets.
    c1 = enc(P1 ^ IV1, K_LO);
    c2 = enc(P2 ^ c1, K_LO);
    send(128'hA1, 1'b0);
    send(IV1, 1'b0);
    send(P1, 1'b1);
    recv(c1, 1'b1, 0, "cbc1");
    send(128'h81, 1'b0);
    send(P2, 1'b1);
    recv(c2, 1'b1, 0, "cbc2");
    check("cbc_ctx2", {128'h0, dut.ctx_iv[2]}, {128'h0, c2});

    // CBC decrypt of the same chain on ctx 1 recovers the plaintexts.
    send(128'h65, 1'b0);
    send(IV1, 1'b0);
    send(c1, 1'b0);
    recv(P1, 1'b0, 0, "cbcd1");
    send(c2, 1'b1);
    recv(P2, 1'b1, 0, "cbcd2");
    check("cbcd_ctx1", {128'h0, dut.ctx_iv[1]}, {128'h0, c2});

    // tlast on the IV beat aborts without touching the context or the core.
    b_st = starts;
    send(128'hA1, 1'b0);
    send(128'h5555, 1'b1);
    repeat (3) @(negedge clk);
    check("abort_ctx2",  {128'h0, dut.ctx_iv[2]}, {128'h0, c2});
    check("abort_nostart", 256'(starts - b_st), 256'd0);

    // CTR counter wrap on ctx 3, with 10 cycles of output backpressure.
    b_cin = ncin;
    send(128'hE2, 1'b0);
    send(IVC, 1'b0);
    send(D0, 1'b0);
    axis.s_tdata  = D1;
    axis.s_tlast  = 1'b1;
    axis.s_tvalid = 1'b1;
    recv(D0 ^ enc(IVC, K_LO), 1'b0, 10, "ctr0");
    send(D1, 1'b1);
    recv(D1 ^ enc(IVC1, K_LO), 1'b1, 0, "ctr1");
    check("ctr_cin0", {128'h0, cin_log[b_cin % 8]},       {128'h0, IVC});
    check("ctr_cin1", {128'h0, cin_log[(b_cin + 1) % 8]}, {128'h0, IVC1});
    check("ctr_ctx3", {128'h0, dut.ctx_iv[3]},            {128'h0, IVC2});

    // Illegal mode with three trailing beats, then a normal packet.
    b_err = errs_seen; b_mv = mvalid_seen;
    send(128'h03, 1'b0);
    send(128'h1, 1'b0);
    send(128'h2, 1'b0);
    send(128'h3, 1'b1);
    repeat (3) @(negedge clk);
    check("illegal_err_once", 256'(errs_seen - b_err),  256'd1);
    check("illegal_no_valid", 256'(mvalid_seen - b_mv), 256'd0);
    send(128'h00, 1'b0);
    send(P3, 1'b1);
    recv(enc(P3, K_LO), 1'b1, 0, "after_err");

    // Illegal command carrying tlast stays in CMD.
    b_err = errs_seen;
    send(128'h07, 1'b1);
    send(128'h00, 1'b0);
    send(P0, 1'b1);
    recv(enc(P0, K_LO), 1'b1, 0, "after_err_last");
    check("illegal_last_err", 256'(errs_seen - b_err), 256'd1);

    // Reset while the core is busy, then a stray core_done.
    auto_en = 1'b0;
    b_mv = mvalid_seen;
    send(128'h00, 1'b0);
    send(P5, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    repeat (4) @(negedge clk);
    check("rstw_no_valid", 256'(mvalid_seen - b_mv), 256'd0);
    for (int i = 0; i < 4; i++) begin
      check("rstw_ctx_zero", {128'h0, dut.ctx_iv[i]}, 256'd0);
    end
    check("rstw_state_cmd", 256'(dut.state), 256'd0);
    check("rstw_ready",     {255'h0, axis.s_tready}, 256'd1);
    check("rstw_key_zero",  core_key, 256'd0);
    auto_en = 1'b1;
    send(128'h00, 1'b0);
    send(P5, 1'b1);
    recv(enc(P5, 128'h0), 1'b1, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
